// File: rtl/pipe_ctrl_defs.sv
// Shared definitions for the pipeline hazard-control slice.
//   state_t     : controller state encoding (RUN / BUSY)
//   REG_ADDR_W  : default register-file address width
//   X0          : index of the hard-wired zero register
package pipe_ctrl_defs;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int REG_ADDR_W = 5;
    localparam int X0         = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, usable for any performance-event count.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low, clears the count
//   inc   : count one event on this edge
//   count : current value, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Producer-side hazard control for the 5-stage RISC-V pipeline: load-use
// bubbles, taken-branch flushes and multi-cycle MDU occupancy of Execute.
// Ports:
//   clk, rst_n                     : clock (rising edge), async active-low reset
//   Rs1_D, Rs2_D, UseRs1_D/UseRs2_D: decode-stage source operands and use flags
//   RD_E, RegWriteE, MemReadE      : execute-stage destination / load info
//   PCSrcE                         : branch/jump taken in Execute
//   MduStartE, MduDone             : MDU op start in Execute / MDU result valid
//   StallF/D/E, FlushD/E/M         : pipeline register controls (combinational)
//   mdu_timeout_err                : sticky MDU timeout flag
//   stall_count                    : saturating count of cycles with StallF=1
module pipeline_stall_ctrl #(
    parameter int REG_ADDR_W  = pipe_ctrl_defs::REG_ADDR_W,
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1_D,
    input  logic [REG_ADDR_W-1:0] Rs2_D,
    input  logic                  UseRs1_D,
    input  logic                  UseRs2_D,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic                  RegWriteE,
    input  logic                  MemReadE,
    input  logic                  PCSrcE,
    input  logic                  MduStartE,
    input  logic                  MduDone,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  mdu_timeout_err,
    output logic [CNT_W-1:0]      stall_count
);

    import pipe_ctrl_defs::*;

    localparam int BUSY_W = $clog2(MDU_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [BUSY_W-1:0] busy_cnt, busy_cnt_nxt;
    logic              timeout_hit;
    logic              load_use;
    logic              stall_f, stall_d, stall_e;
    logic              flush_d, flush_e, flush_m;

    assign load_use = MemReadE && RegWriteE && (RD_E != REG_ADDR_W'(X0)) &&
                      ((UseRs1_D && (RD_E == Rs1_D)) ||
                       (UseRs2_D && (RD_E == Rs2_D)));

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        timeout_hit  = 1'b0;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_m      = 1'b0;

        case (state)
            ST_RUN: begin
                if (PCSrcE) begin
                    // Taken branch squashes the dependent instruction, so a
                    // pending load-use bubble is pointless.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (MduStartE) begin
                    // A single-cycle MDU result needs no hold at all.
                    if (!MduDone) begin
                        stall_f      = 1'b1;
                        stall_d      = 1'b1;
                        stall_e      = 1'b1;
                        flush_m      = 1'b1;
                        state_nxt    = ST_BUSY;
                        busy_cnt_nxt = BUSY_W'(1);
                    end
                end else if (load_use) begin
                    // One bubble: next cycle the load sits in Mem and the
                    // forwarding network covers the dependency.
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end

            ST_BUSY: begin
                if (MduDone) begin
                    // Release cycle: Execute still holds the MDU op, so
                    // branch/load-use information is not meaningful yet.
                    state_nxt    = ST_RUN;
                    busy_cnt_nxt = '0;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                    if (busy_cnt == BUSY_W'(MDU_TIMEOUT)) begin
                        // Give up on the MDU; stalls still hold this cycle
                        // and drop once back in RUN.
                        timeout_hit  = 1'b1;
                        state_nxt    = ST_RUN;
                        busy_cnt_nxt = '0;
                    end else begin
                        busy_cnt_nxt = busy_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt    = ST_RUN;
                busy_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign StallF = rst_n & stall_f;
    assign StallD = rst_n & stall_d;
    assign StallE = rst_n & stall_e;
    assign FlushD = rst_n & flush_d;
    assign FlushE = rst_n & flush_e;
    assign FlushM = rst_n & flush_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_RUN;
            busy_cnt        <= '0;
            mdu_timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            if (timeout_hit) begin
                mdu_timeout_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallF),
        .count (stall_count)
    );

endmodule
